// File: rtl/exec_mem_pkg.sv
// Shared definitions for the execute/memory stage: ALU op codes, memory map
// constants and byte-lane mask helpers.
package exec_mem_pkg;

  typedef enum logic [5:0] {
    OP_NOP     = 6'd0,
    OP_ADD     = 6'd1,
    OP_SUB     = 6'd2,
    OP_AND     = 6'd3,
    OP_OR      = 6'd4,
    OP_XOR     = 6'd5,
    OP_NOR     = 6'd6,
    OP_SLT     = 6'd7,
    OP_SLTU    = 6'd8,
    OP_SLL     = 6'd9,
    OP_SRL     = 6'd10,
    OP_SRA     = 6'd11,
    OP_LUI     = 6'd12,
    OP_MULT    = 6'd13,
    OP_MULTU   = 6'd14,
    OP_MFHI    = 6'd15,
    OP_MFLO    = 6'd16,
    OP_MTHI    = 6'd17,
    OP_MTLO    = 6'd18,
    OP_MEMADDR = 6'd19
  } alu_op_e;

  localparam int          RAM_WORDS = 1024;
  localparam logic [15:0] SEG7_ADDR = 16'h8000;
  localparam logic [15:0] LED_ADDR  = 16'h8004;

  // Expands a 4-bit byte-lane select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    return (old_word & ~lane_mask(mask)) | (new_word & lane_mask(mask));
  endfunction

endpackage

// File: rtl/exec_mem_unit_if.sv
// Bus bundle between the decode stage and the execute/memory stage, including
// the registered stage outputs, forwarding copies and memory-mapped outputs.
interface exec_mem_unit_if;

  logic [5:0]  op_i;
  logic [31:0] regaData_i;
  logic [31:0] regbData_i;
  logic [31:0] rt_data_i;
  logic        regcWr_i;
  logic [4:0]  regcAddr_i;
  logic        memWr_i;
  logic        memRr_i;
  logic [3:0]  w_mask_i;
  logic [3:0]  r_mask_i;
  logic [31:0] inst_debug_i;
  logic [31:0] pc_debug_i;

  logic [31:0] regcData;
  logic [4:0]  regcAddr;
  logic        regcWr;
  logic [31:0] inst_debug;
  logic [31:0] pc_debug;
  logic        exu_regWr;
  logic [31:0] exu_data;
  logic [4:0]  exu_regAddr;
  logic [31:0] rdData;
  logic [31:0] seg7;
  logic [31:0] led_data;

  modport master (
    output op_i, regaData_i, regbData_i, rt_data_i, regcWr_i, regcAddr_i,
           memWr_i, memRr_i, w_mask_i, r_mask_i, inst_debug_i, pc_debug_i,
    input  regcData, regcAddr, regcWr, inst_debug, pc_debug,
           exu_regWr, exu_data, exu_regAddr, rdData, seg7, led_data
  );

  modport slave (
    input  op_i, regaData_i, regbData_i, rt_data_i, regcWr_i, regcAddr_i,
           memWr_i, memRr_i, w_mask_i, r_mask_i, inst_debug_i, pc_debug_i,
    output regcData, regcAddr, regcWr, inst_debug, pc_debug,
           exu_regWr, exu_data, exu_regAddr, rdData, seg7, led_data
  );

endinterface

// File: rtl/exec_data_mem.sv
// 1024-word byte-maskable data RAM plus the seg7/led memory-mapped registers,
// driven by the already-registered memory fields of the stage.
module exec_data_mem
  import exec_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [3:0]  mem_wmask,
  input  logic [3:0]  mem_rmask,
  output logic [31:0] rd_data,
  output logic [31:0] seg7,
  output logic [31:0] led_data
);

  logic [31:0] ram [0:RAM_WORDS-1];
  logic [9:0]  ram_idx;
  logic        is_ram;
  logic        is_seg7;
  logic        is_led;
  logic [31:0] raw_word;

  assign ram_idx = mem_addr[11:2];
  assign is_ram  = ~mem_addr[15];
  assign is_seg7 = (mem_addr == SEG7_ADDR);
  assign is_led  = (mem_addr == LED_ADDR);

  // RAM has no reset; a store dropped by reset is covered by mem_wr clearing.
  always_ff @(posedge clk) begin
    if (mem_wr && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) begin
          ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg7     <= '0;
      led_data <= '0;
    end else if (mem_wr) begin
      if (is_seg7) seg7     <= merge_bytes(seg7, mem_wdata, mem_wmask);
      if (is_led)  led_data <= merge_bytes(led_data, mem_wdata, mem_wmask);
    end
  end

  always_comb begin
    raw_word = '0;
    if (is_ram)       raw_word = ram[ram_idx];
    else if (is_seg7) raw_word = seg7;
    else if (is_led)  raw_word = led_data;
  end

  assign rd_data = mem_rd ? (raw_word & lane_mask(mem_rmask)) : 32'h0;

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory pipeline stage: inline ALU with HI/LO multiply registers,
// stage output registers and the data memory sub-block.
module exec_mem_unit
  import exec_mem_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  exec_mem_unit_if.slave bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic [31:0] regc_data_q;
  logic [4:0]  regc_addr_q;
  logic        regc_wr_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [15:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_wr_q;
  logic        mem_rd_q;
  logic [3:0]  mem_wmask_q;
  logic [3:0]  mem_rmask_q;

  assign a      = bus.regaData_i;
  assign b      = bus.regbData_i;
  assign shamt  = a[4:0];
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'h0, a} * {32'h0, b};

  always_comb begin
    result = '0;
    case (bus.op_i)
      OP_ADD, OP_MEMADDR: result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOR:   result = ~(a | b);
      OP_SLT:   result = {31'h0, $signed(a) < $signed(b)};
      OP_SLTU:  result = {31'h0, a < b};
      OP_SLL:   result = b << shamt;
      OP_SRL:   result = b >> shamt;
      OP_SRA:   result = $unsigned($signed(b) >>> shamt);
      OP_LUI:   result = {b[15:0], 16'h0};
      OP_MFHI:  result = hi;
      OP_MFLO:  result = lo;
      default:  result = '0;
    endcase
  end

  // HI/LO are only read back through MFHI/MFLO in a later cycle, so no bypass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (bus.op_i)
        OP_MULT: begin
          hi <= prod_s[63:32];
          lo <= prod_s[31:0];
        end
        OP_MULTU: begin
          hi <= prod_u[63:32];
          lo <= prod_u[31:0];
        end
        OP_MTHI: hi <= a;
        OP_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regc_data_q <= '0;
      regc_addr_q <= '0;
      regc_wr_q   <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_rmask_q <= '0;
    end else begin
      regc_data_q <= result;
      regc_addr_q <= bus.regcAddr_i;
      regc_wr_q   <= bus.regcWr_i;
      inst_q      <= bus.inst_debug_i;
      pc_q        <= bus.pc_debug_i;
      mem_addr_q  <= result[15:0];
      mem_wdata_q <= bus.rt_data_i;
      mem_wr_q    <= bus.memWr_i;
      mem_rd_q    <= bus.memRr_i;
      mem_wmask_q <= bus.w_mask_i;
      mem_rmask_q <= bus.r_mask_i;
    end
  end

  assign bus.regcData    = regc_data_q;
  assign bus.regcAddr    = regc_addr_q;
  assign bus.regcWr      = regc_wr_q;
  assign bus.inst_debug  = inst_q;
  assign bus.pc_debug    = pc_q;
  assign bus.exu_data    = result;
  assign bus.exu_regWr   = bus.regcWr_i;
  assign bus.exu_regAddr = bus.regcAddr_i;

  exec_data_mem u_data_mem (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr_q),
    .mem_wdata (mem_wdata_q),
    .mem_wr    (mem_wr_q),
    .mem_rd    (mem_rd_q),
    .mem_wmask (mem_wmask_q),
    .mem_rmask (mem_rmask_q),
    .rd_data   (bus.rdData),
    .seg7      (bus.seg7),
    .led_data  (bus.led_data)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: expected stage results and load data
// are queued when stimulus is driven and compared when the stage produces them.
module tb_exec_mem_unit;
  import exec_mem_pkg::*;

  logic clk;
  logic resetn;
  exec_mem_unit_if bus ();

  exec_mem_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] inst;
    logic [31:0] pc;
  } stage_exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        chk_exu;
  } alu_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [3:0]  wm;
    logic [3:0]  rm;
    logic [31:0] exp;
  } mem_vec_t;

  stage_exp_t  stage_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc = 32'h0000_0400;
  logic [31:0] last_inst;
  logic [31:0] last_pc;

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rt, input logic wr, input logic [4:0] waddr,
                       input logic mw, input logic mr, input logic [3:0] wm, input logic [3:0] rm);
    last_inst = {op, a[13:0], b[11:0]};
    last_pc   = cur_pc;
    cur_pc    = cur_pc + 32'd4;
    bus.op_i         = op;
    bus.regaData_i   = a;
    bus.regbData_i   = b;
    bus.rt_data_i    = rt;
    bus.regcWr_i     = wr;
    bus.regcAddr_i   = waddr;
    bus.memWr_i      = mw;
    bus.memRr_i      = mr;
    bus.w_mask_i     = wm;
    bus.r_mask_i     = rm;
    bus.inst_debug_i = last_inst;
    bus.pc_debug_i   = last_pc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] obs [8];
    string       nm  [8] = '{"regcData", "regcAddr", "regcWr", "inst_debug",
                             "pc_debug", "rdData", "seg7", "led_data"};
    resetn = 1'b1;
    drive(OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    #2 resetn = 1'b0;
    #2;
    obs = '{bus.regcData, {27'h0, bus.regcAddr}, {31'h0, bus.regcWr}, bus.inst_debug,
            bus.pc_debug, bus.rdData, bus.seg7, bus.led_data};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_%s: got %h expected 00000000", nm[i], obs[i]);
      end
    end
    checks++;
    if (bus.exu_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.exu_data);
    end
    step();
    step();
    checks++;
    if (bus.regcData !== 32'h0 || bus.pc_debug !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_held: got regcData=%h pc_debug=%h expected 0/0",
               bus.regcData, bus.pc_debug);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_add_wrap;
    stage_exp_t e;
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0, 4'h0, 4'h0);
    stage_q.push_back('{32'h0, 5'd5, 1'b1, last_inst, last_pc});
    #1;
    checks++;
    if (bus.exu_data !== 32'h0 || bus.exu_regWr !== 1'b1 || bus.exu_regAddr !== 5'd5) begin
      errors++;
      $display("[TB] FAIL add_wrap_exu: got data=%h wr=%b addr=%0d expected 00000000/1/5",
               bus.exu_data, bus.exu_regWr, bus.exu_regAddr);
    end
    step();
    e = stage_q.pop_front();
    checks++;
    if (bus.regcData !== e.data || bus.regcAddr !== e.addr || bus.regcWr !== e.wr) begin
      errors++;
      $display("[TB] FAIL add_wrap_regc: got %h/%0d/%b expected %h/%0d/%b",
               bus.regcData, bus.regcAddr, bus.regcWr, e.data, e.addr, e.wr);
    end
    checks++;
    if (bus.inst_debug !== e.inst || bus.pc_debug !== e.pc) begin
      errors++;
      $display("[TB] FAIL add_wrap_debug: got %h/%h expected %h/%h",
               bus.inst_debug, bus.pc_debug, e.inst, e.pc);
    end
  endtask

  task automatic test_alu_ops;
    stage_exp_t e;
    alu_vec_t   v [17] = '{
      '{OP_SUB,     32'h5,         32'h7,         32'hFFFF_FFFE, 1'b1},
      '{OP_AND,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1},
      '{OP_OR,      32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b1},
      '{OP_XOR,     32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b1},
      '{OP_NOR,     32'h0F0F_0000, 32'h00F0_000F, 32'hF000_FFF0, 1'b1},
      '{OP_SLT,     32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1},
      '{OP_SLTU,    32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1},
      '{OP_SLT,     32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1},
      '{OP_SLTU,    32'h1,         32'hFFFF_FFFF, 32'h1,         1'b1},
      '{OP_SLL,     32'h3F,        32'h1,         32'h8000_0000, 1'b1},
      '{OP_SRL,     32'h4,         32'h8000_0000, 32'h0800_0000, 1'b1},
      '{OP_SRA,     32'h4,         32'h8000_0000, 32'hF800_0000, 1'b1},
      '{OP_SRA,     32'h4,         32'h4000_0000, 32'h0400_0000, 1'b1},
      '{OP_LUI,     32'h0,         32'hABCD_1234, 32'h1234_0000, 1'b1},
      '{OP_MEMADDR, 32'h100,       32'h24,        32'h0000_0124, 1'b1},
      '{OP_NOP,     32'h1,         32'h2,         32'h0,         1'b1},
      '{6'd20,      32'h1,         32'h2,         32'h0,         1'b1}
    };
    for (int i = 0; i < 17; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 32'h0, 1'b1, 5'(i + 1), 1'b0, 1'b0, 4'h0, 4'h0);
      stage_q.push_back('{v[i].exp, 5'(i + 1), 1'b1, last_inst, last_pc});
      #1;
      checks++;
      if (bus.exu_data !== v[i].exp) begin
        errors++;
        $display("[TB] FAIL alu_exu_op%0d: got %h expected %h", v[i].op, bus.exu_data, v[i].exp);
      end
      step();
      e = stage_q.pop_front();
      checks++;
      if (bus.regcData !== e.data || bus.regcAddr !== e.addr) begin
        errors++;
        $display("[TB] FAIL alu_regc_op%0d: got %h/%0d expected %h/%0d",
                 v[i].op, bus.regcData, bus.regcAddr, e.data, e.addr);
      end
    end
  endtask

  task automatic test_hilo;
    stage_exp_t e;
    alu_vec_t   v [10] = '{
      '{OP_MULT,  32'hFFFF_FFFE, 32'h3, 32'h0,         1'b1},
      '{OP_MFHI,  32'h0,         32'h0, 32'hFFFF_FFFF, 1'b1},
      '{OP_MFLO,  32'h0,         32'h0, 32'hFFFF_FFFA, 1'b1},
      '{OP_MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0,         1'b1},
      '{OP_MFHI,  32'h0,         32'h0, 32'h0000_0002, 1'b1},
      '{OP_MFLO,  32'h0,         32'h0, 32'hFFFF_FFFA, 1'b1},
      '{OP_MTHI,  32'hDEAD_BEEF, 32'h0, 32'h0,         1'b0},
      '{OP_MTLO,  32'h1234_5678, 32'h0, 32'h0,         1'b0},
      '{OP_MFHI,  32'h0,         32'h0, 32'hDEAD_BEEF, 1'b1},
      '{OP_MFLO,  32'h0,         32'h0, 32'h1234_5678, 1'b1}
    };
    for (int i = 0; i < 10; i++) begin
      drive(v[i].op, v[i].a, v[i].b, 32'h0, 1'b1, 5'd9, 1'b0, 1'b0, 4'h0, 4'h0);
      if (v[i].chk_exu) stage_q.push_back('{v[i].exp, 5'd9, 1'b1, last_inst, last_pc});
      step();
      if (v[i].chk_exu) begin
        e = stage_q.pop_front();
        checks++;
        if (bus.regcData !== e.data) begin
          errors++;
          $display("[TB] FAIL hilo_step%0d_op%0d: got %h expected %h",
                   i, v[i].op, bus.regcData, e.data);
        end
      end
    end
  endtask

  task automatic test_memory;
    logic [31:0] exp_rd;
    mem_vec_t    v [15] = '{
      '{16'h0000, 32'hCAFE_F00D, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h0010, 32'h0000_0000, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h0010, 32'hAABB_CCDD, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0},
      '{16'h0010, 32'h0,         1'b0, 1'b1, 4'h0, 4'hF, 32'h0000_CCDD},
      '{16'h0014, 32'h1122_3344, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h0014, 32'h0,         1'b0, 1'b1, 4'h0, 4'h6, 32'h0022_3300},
      '{16'h8000, 32'h1234_5678, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h8004, 32'h1234_5678, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h0000, 32'h0,         1'b0, 1'b1, 4'h0, 4'hF, 32'hCAFE_F00D},
      '{16'h8000, 32'h0,         1'b0, 1'b1, 4'h0, 4'hF, 32'h1234_5678},
      '{16'h8004, 32'h0,         1'b0, 1'b1, 4'h0, 4'hC, 32'h1234_0000},
      '{16'h8008, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0},
      '{16'h8008, 32'h0,         1'b0, 1'b1, 4'h0, 4'hF, 32'h0},
      '{16'h8000, 32'h0000_00AB, 1'b1, 1'b0, 4'h1, 4'h0, 32'h0},
      '{16'h8000, 32'h0,         1'b0, 1'b1, 4'h0, 4'hF, 32'h1234_56AB}
    };
    for (int i = 0; i < 15; i++) begin
      drive(OP_MEMADDR, {16'h0, v[i].addr}, 32'h0, v[i].wdata, 1'b0, 5'd0,
            v[i].wr, v[i].rd, v[i].wm, v[i].rm);
      rd_q.push_back(v[i].exp);
      step();
      exp_rd = rd_q.pop_front();
      checks++;
      if (bus.rdData !== exp_rd) begin
        errors++;
        $display("[TB] FAIL mem_row%0d_addr%h: got %h expected %h", i, v[i].addr, bus.rdData, exp_rd);
      end
    end
    checks++;
    if (bus.seg7 !== 32'h1234_56AB || bus.led_data !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL mmio_regs: got seg7=%h led=%h expected 123456ab/12345678",
               bus.seg7, bus.led_data);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] exp_rd;
    drive(OP_MTHI, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    drive(OP_MTLO, 32'h66, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    drive(OP_MEMADDR, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 1'b0, 4'hF, 4'h0);
    step();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.regcData !== 32'h0 || bus.regcWr !== 1'b0 || bus.regcAddr !== 5'd0 ||
        bus.inst_debug !== 32'h0 || bus.pc_debug !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_stage: got data=%h wr=%b addr=%0d inst=%h pc=%h expected all 0",
               bus.regcData, bus.regcWr, bus.regcAddr, bus.inst_debug, bus.pc_debug);
    end
    checks++;
    if (bus.seg7 !== 32'h0 || bus.led_data !== 32'h0 || bus.rdData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_mmio: got seg7=%h led=%h rdData=%h expected all 0",
               bus.seg7, bus.led_data, bus.rdData);
    end
    drive(OP_NOP, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    drive(OP_MEMADDR, 32'h10, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0, 4'hF);
    rd_q.push_back(32'h0000_CCDD);
    step();
    exp_rd = rd_q.pop_front();
    checks++;
    if (bus.rdData !== exp_rd) begin
      errors++;
      $display("[TB] FAIL midreset_store_dropped: got %h expected %h", bus.rdData, exp_rd);
    end
    checks++;
    if (bus.regcData !== 32'h10) begin
      errors++;
      $display("[TB] FAIL first_edge_after_reset: got %h expected 00000010", bus.regcData);
    end
    drive(OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    checks++;
    if (bus.exu_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_hi: got %h expected 00000000", bus.exu_data);
    end
    drive(OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    checks++;
    if (bus.exu_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_lo: got %h expected 00000000", bus.exu_data);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_alu_ops();
    test_hilo();
    test_memory();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 op_i  in  6  ALU operation code, encodings per REQ-012.
REQ-004 regaData_i, regbData_i  in  32 each  operands A and B.
REQ-005 rt_data_i  in  32  store data.
REQ-006 regcWr_i  in  1  write-back enable; regcAddr_i  in  5  write-back register.
REQ-007 memWr_i, memRr_i  in  1 each  store / load request.
REQ-008 w_mask_i, r_mask_i  in  4 each  byte-lane masks; bit n selects byte n.
REQ-009 inst_debug_i, pc_debug_i  in  32 each  debug pass-through inputs.
REQ-010 regcData, regcAddr, regcWr, inst_debug, pc_debug  out  registered stage outputs.
REQ-011 exu_regWr 1, exu_data 32, exu_regAddr 5  out, combinational forwarding copies of the current-cycle result; rdData 32, seg7 32, led_data 32  out.

Function
REQ-012 op encodings (decimal): 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLT, 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 LUI, 13 MULT, 14 MULTU, 15 MFHI, 16 MFLO, 17 MTHI, 18 MTLO, 19 MEMADDR; any other code SHALL produce result 0.
REQ-013 ADD/SUB/MEMADDR SHALL compute A+B or A-B modulo 2^32, with no overflow detection.
REQ-014 Shift ops SHALL shift B by A[4:0]; SRA SHALL be arithmetic; LUI SHALL give {B[15:0],16'h0}.
REQ-015 SLT SHALL compare signed and SLTU unsigned; the result SHALL be 1 or 0.
REQ-016 MULT/MULTU SHALL form the 64-bit signed/unsigned product A*B; HI gets bits 63:32 and LO gets bits 31:0, written at the same edge; the result SHALL be 0.
REQ-017 MTHI/MTLO SHALL write A into HI/LO at the edge; MFHI/MFLO SHALL return the current HI/LO register value.
REQ-018 HI/LO written at edge N SHALL be visible to MFHI/MFLO issued in cycle N+1, with no bypass needed.
REQ-019 exu_data SHALL be the combinational result; exu_regWr SHALL equal regcWr_i; exu_regAddr SHALL equal regcAddr_i.
REQ-020 At each edge the stage SHALL register regcData, regcAddr, regcWr and the debug signals.
REQ-021 At each edge the stage SHALL also register the memory fields: addr (the result), store data rt_data_i, memWr, memRr and both masks.
REQ-022 The data memory SHALL hold 1024 words at byte addresses 0x000–0xFFF, indexed by addr[11:2], using the registered memory fields.
REQ-023 A store SHALL write only the mask-selected byte lanes at the edge following registration.
REQ-024 Memory-mapped registers SHALL decode at addr[15]=1: 0x8000 is seg7 and 0x8004 is led_data.
REQ-025 Memory-mapped registers SHALL be byte-masked writable and readable.
REQ-026 rdData SHALL be the combinational word read with unselected bytes zeroed, and SHALL be 0 when the registered memRr=0.
REQ-027 Sign or zero extension of loaded bytes is downstream, not in this block.
REQ-028 Other unmapped addresses with addr[15]=1 SHALL ignore writes and read 0.
REQ-029 A read of the same address written at the previous edge SHALL return the new data.

Reset
REQ-030 On resetn=0, all registered outputs, stored memory fields, HI, LO, seg7 and led_data SHALL clear to 0 immediately.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 On release of resetn, the first edge SHALL behave as a normal cycle.
REQ-033 Reset asserted mid-store SHALL suppress that write.

Structure
REQ-034 Op encodings and the memory-mapped address constants SHALL live in the shared package exec_mem_pkg.
REQ-035 The data memory with its memory-mapped registers SHALL be one sub-module, exec_data_mem.
REQ-036 The ALU and HI/LO logic SHALL be inline in exec_mem_unit.

Verification
REQ-037 Bench SHALL apply ADD A=0xFFFFFFFF, B=1 and require regcData=0 on the next edge and exu_data=0 in the same cycle.
REQ-038 Bench SHALL apply MULT A=0xFFFFFFFE(-2), B=3, then MFHI, then MFLO, and require 0xFFFFFFFF then 0xFFFFFFFA.
REQ-039 Bench SHALL apply MULTU with the same operands and require HI=0x00000002, LO=0xFFFFFFFA.
REQ-040 Bench SHALL store 0xAABBCCDD to 0x10 with w_mask=0011, then load with r_mask=1111, and require rdData=0x0000CCDD.
REQ-041 Bench SHALL store 0x12345678 to 0x8000 and 0x8004 and require seg7=0x12345678, led_data=0x12345678, and RAM word 0 unchanged.
REQ-042 Bench SHALL assert resetn low between edges and require all outputs, HI, LO and memory-mapped registers to be 0 at once, and a store in flight to be dropped.
